reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised register file for the multicycle CPU datapath: 2 read ports, 1 write port.
//  Adds over the fixed 32x32 file: async reset clear, selectable write-first bypass,
//  hardwired zero register and a per-register busy scoreboard for multicycle hazard checks.
//  Sits between decode (rr1/rr2) and writeback (wr/wd/regwr).
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width in bits; depth = 2**AW registers
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, is never busy
//  BYPASS    1   1: write-first (same-edge write is visible on read); 0: read-first (old value)
// PORTS
//  clk       in   1    clock, rising edge
//  rst       in   1    reset, asynchronous, active-high
//  rr1       in   AW   read address, port 1
//  rr2       in   AW   read address, port 2
//  rd1       out  DW   read data, port 1, registered
//  rd2       out  DW   read data, port 2, registered
//  rd1_busy  out  1    busy flag of rr1, registered alongside rd1
//  rd2_busy  out  1    busy flag of rr2, registered alongside rd2
//  regwr     in   1    write enable
//  wr        in   AW   write address
//  wd        in   DW   write data
//  mark      in   1    mark register mark_addr busy (pending producer issued)
//  mark_addr in   AW   register to mark busy
//  busy_vec  out  2**AW  full scoreboard, bit i = register i busy
// BEHAVIOUR
//  - Reset (async, rst=1): all registers, rd1, rd2, rd1_busy, rd2_busy, busy_vec <= 0 at once,
//    independent of clk. Held while rst=1. First write is accepted on the first rising edge after rst falls.
//  - Write: on a rising edge with regwr=1, reg[wr] <= wd. If ZERO_REG=1 and wr=0, no write.
//  - Read: 1-cycle latency. On each rising edge, rdN <= reg[rrN] sampled at that edge.
//    BYPASS=1: if regwr=1 and wr==rrN (and not the zero register), rdN <= wd.
//    BYPASS=0: rdN <= the pre-write contents.
//    ZERO_REG=1 and rrN=0: rdN <= 0 in every case.
//  - rr1==rr2 is legal; both ports return identical data and busy.
//  - Scoreboard, updated on each rising edge:
//    regwr=1 clears busy[wr]; mark=1 sets busy[mark_addr].
//    mark and regwr on the same address in the same cycle: set wins (new producer pending).
//    ZERO_REG=1: busy[0] stays 0; marks and clears of register 0 are ignored.
//  - rdN_busy <= post-update busy[rrN] when BYPASS=1; pre-update busy[rrN] when BYPASS=0.
//    Keeps flag and data consistent.
//  - busy_vec is the registered scoreboard (current state, no bypass).
//  - Address arithmetic is unsigned and exact width AW; no wrap or overflow is possible.
//    Data is stored verbatim; no sign handling.
//  - No X propagation: every output is a defined value after reset.
// STRUCTURE
//  - Shared package rf_pkg:
//    RF_DW=32, RF_AW=5
//    register-number constants: REG_ZERO=0, REG_AT=1 ... REG_RA=31
//    typedefs rf_addr_t [RF_AW-1:0], rf_data_t [RF_DW-1:0]
//  - One sub-module: rf_scoreboard (AW, ZERO_REG). Holds the busy bits and the set/clear priority.
//    Outputs busy_vec and the next-state vector used for bypassed busy reads.
//  - Storage array, bypass muxes and output registers live in reg_file_param.
// TESTING
//  1. Reset: write 0x0123 to r2, then assert rst mid-cycle (between edges).
//     -> rd1/rd2/busy_vec are 0 immediately; reading r2 after release gives 0.
//  2. Bypass: BYPASS=1, regwr=1, wr=3, wd=0xDEADBEEF, rr1=3 on the same edge.
//     -> rd1=0xDEADBEEF one edge later.
//     Repeat with BYPASS=0 -> rd1 = old value (0), then 0xDEADBEEF on the next edge.
//  3. Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0, mark r0, read rr1=0.
//     -> rd1=0, rd1_busy=0, busy_vec[0]=0.
//     With ZERO_REG=0 -> rd1=0xFFFFFFFF.
//  4. Scoreboard: mark r5, then read rr2=5 on the next edge -> rd2_busy=1.
//     Write r5=0x55 -> busy_vec[5]=0; a read issued at the write edge gives rd2=0x55, rd2_busy=0.
//  5. Collision: mark=1, mark_addr=7, regwr=1, wr=7 on the same edge.
//     -> busy_vec[7]=1 and reg7 = wd.
//     rr1=rr2=7 -> both ports return identical data and busy.
//  6. Parameter sweep: DW=16, AW=3. Write i*0x1111 to r1..r7, then read all pairs.
//     -> exact values; addresses 0..7 only; all outputs 0 straight after reset.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, register numbers and types for the register file
package rf_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // architectural register numbers
  localparam rf_addr_t REG_ZERO = 5'd0,  REG_AT = 5'd1,  REG_V0 = 5'd2,  REG_V1 = 5'd3;
  localparam rf_addr_t REG_A0   = 5'd4,  REG_A1 = 5'd5,  REG_A2 = 5'd6,  REG_A3 = 5'd7;
  localparam rf_addr_t REG_T0   = 5'd8,  REG_T1 = 5'd9,  REG_T2 = 5'd10, REG_T3 = 5'd11;
  localparam rf_addr_t REG_T4   = 5'd12, REG_T5 = 5'd13, REG_T6 = 5'd14, REG_T7 = 5'd15;
  localparam rf_addr_t REG_S0   = 5'd16, REG_S1 = 5'd17, REG_S2 = 5'd18, REG_S3 = 5'd19;
  localparam rf_addr_t REG_S4   = 5'd20, REG_S5 = 5'd21, REG_S6 = 5'd22, REG_S7 = 5'd23;
  localparam rf_addr_t REG_T8   = 5'd24, REG_T9 = 5'd25, REG_K0 = 5'd26, REG_K1 = 5'd27;
  localparam rf_addr_t REG_GP   = 5'd28, REG_SP = 5'd29, REG_FP = 5'd30, REG_RA = 5'd31;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits for multicycle hazard tracking
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwr,
  input  logic [AW-1:0]       wr,
  input  logic                mark,
  input  logic [AW-1:0]       mark_addr,
  output logic [(2**AW)-1:0]  busy_vec,
  output logic [(2**AW)-1:0]  busy_next
);

  // clear on writeback first, then set on issue so a new pending producer wins a collision
  always_comb begin
    busy_next = busy_vec;
    if (regwr) busy_next[wr] = 1'b0;
    if (mark) busy_next[mark_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // scoreboard state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_next;
  end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R1W register file with bypass and busy scoreboard
module reg_file_param
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rr1,
  input  logic [AW-1:0]       rr2,
  output logic [DW-1:0]       rd1,
  output logic [DW-1:0]       rd2,
  output logic                rd1_busy,
  output logic                rd2_busy,
  input  logic                regwr,
  input  logic [AW-1:0]       wr,
  input  logic [DW-1:0]       wd,
  input  logic                mark,
  input  logic [AW-1:0]       mark_addr,
  output logic [(2**AW)-1:0]  busy_vec
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy_next;
  logic            wr_en;
  logic [DW-1:0]   rd1_d, rd2_d;
  logic            rd1_busy_d, rd2_busy_d;

  rf_scoreboard #(.AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .regwr     (regwr),
    .wr        (wr),
    .mark      (mark),
    .mark_addr (mark_addr),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

  // a hardwired register 0 silently drops writes
  assign wr_en = regwr && !((ZERO_REG != 0) && (wr == '0));

  // read muxes: stored value, overridden by same-edge write, overridden by the zero register
  always_comb begin
    rd1_d = regs[rr1];
    rd2_d = regs[rr2];
    if ((BYPASS != 0) && wr_en && (wr == rr1)) rd1_d = wd;
    if ((BYPASS != 0) && wr_en && (wr == rr2)) rd2_d = wd;
    if ((ZERO_REG != 0) && (rr1 == '0)) rd1_d = '0;
    if ((ZERO_REG != 0) && (rr2 == '0)) rd2_d = '0;
    // busy flag follows the same before/after-write view as the data
    rd1_busy_d = (BYPASS != 0) ? busy_next[rr1] : busy_vec[rr1];
    rd2_busy_d = (BYPASS != 0) ? busy_next[rr2] : busy_vec[rr2];
  end

  // storage array, cleared as a whole on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr] <= wd;
    end
  end

  // registered read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1      <= '0;
      rd2      <= '0;
      rd1_busy <= 1'b0;
      rd2_busy <= 1'b0;
    end else begin
      rd1      <= rd1_d;
      rd2      <= rd2_d;
      rd1_busy <= rd1_busy_d;
      rd2_busy <= rd2_busy_d;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param in three configurations
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        regwr, mark;
  logic [4:0]  rr1, rr2, wr, mark_addr;
  logic [31:0] wd;

  logic [31:0] a_rd1, a_rd2, a_bv, b_rd1, b_rd2, b_bv;
  logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;
  logic [15:0] c_rd1, c_rd2;
  logic [7:0]  c_bv;

  // a: write-first, hardwired zero
  reg_file_param #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rr1(rr1), .rr2(rr2), .rd1(a_rd1), .rd2(a_rd2),
    .rd1_busy(a_b1), .rd2_busy(a_b2), .regwr(regwr), .wr(wr), .wd(wd),
    .mark(mark), .mark_addr(mark_addr), .busy_vec(a_bv));

  // b: read-first, ordinary register 0
  reg_file_param #(.DW(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rr1(rr1), .rr2(rr2), .rd1(b_rd1), .rd2(b_rd2),
    .rd1_busy(b_b1), .rd2_busy(b_b2), .regwr(regwr), .wr(wr), .wd(wd),
    .mark(mark), .mark_addr(mark_addr), .busy_vec(b_bv));

  // c: narrow 16x8 file, low bits of the shared stimulus
  reg_file_param #(.DW(16), .AW(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .rr1(rr1[2:0]), .rr2(rr2[2:0]), .rd1(c_rd1), .rd2(c_rd2),
    .rd1_busy(c_b1), .rd2_busy(c_b2), .regwr(regwr), .wr(wr[2:0]), .wd(wd[15:0]),
    .mark(mark), .mark_addr(mark_addr[2:0]), .busy_vec(c_bv));

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: architectural state per configuration
  int cfg_byp [3]  = '{1, 0, 1};
  int cfg_zero [3] = '{1, 0, 1};
  int cfg_aw [3]   = '{5, 5, 3};
  int cfg_dw [3]   = '{32, 32, 16};
  bit [31:0] m_mem [3][32];
  bit        m_busy [3][32];
  bit [31:0] e_rd1 [3], e_rd2 [3], e_bv [3];
  bit        e_b1 [3], e_b2 [3];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 32; j++) begin
        m_mem[k][j] = '0;
        m_busy[k][j] = 1'b0;
      end
      e_rd1[k] = '0; e_rd2[k] = '0; e_bv[k] = '0; e_b1[k] = 1'b0; e_b2[k] = 1'b0;
    end
  endtask

  // one clock edge: reads see the state after this edge's write when bypassing, before it otherwise
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit [31:0] am, dm, w, ma, a1, a2, o1, o2;
      bit ob1, ob2, zr;
      am = (32'd1 << cfg_aw[k]) - 32'd1;
      dm = (cfg_dw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[k]) - 32'd1);
      w = 32'(wr) & am; ma = 32'(mark_addr) & am;
      a1 = 32'(rr1) & am; a2 = 32'(rr2) & am;
      zr = (cfg_zero[k] != 0);
      o1 = m_mem[k][a1]; o2 = m_mem[k][a2];
      ob1 = m_busy[k][a1]; ob2 = m_busy[k][a2];
      if (regwr && !(zr && w == 0)) begin
        m_mem[k][w] = wd & dm;
        m_busy[k][w] = 1'b0;
      end
      if (mark && !(zr && ma == 0)) m_busy[k][ma] = 1'b1;
      e_rd1[k] = (zr && a1 == 0) ? 32'd0 : ((cfg_byp[k] != 0) ? m_mem[k][a1] : o1);
      e_rd2[k] = (zr && a2 == 0) ? 32'd0 : ((cfg_byp[k] != 0) ? m_mem[k][a2] : o2);
      e_b1[k] = (cfg_byp[k] != 0) ? m_busy[k][a1] : ob1;
      e_b2[k] = (cfg_byp[k] != 0) ? m_busy[k][a2] : ob2;
      e_bv[k] = '0;
      for (int j = 0; j < 32; j++) e_bv[k][j] = m_busy[k][j];
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".a_rd1"}, a_rd1, e_rd1[0]);
    check({tag, ".a_rd2"}, a_rd2, e_rd2[0]);
    check({tag, ".a_b1"}, 32'(a_b1), 32'(e_b1[0]));
    check({tag, ".a_b2"}, 32'(a_b2), 32'(e_b2[0]));
    check({tag, ".a_bv"}, a_bv, e_bv[0]);
    check({tag, ".b_rd1"}, b_rd1, e_rd1[1]);
    check({tag, ".b_rd2"}, b_rd2, e_rd2[1]);
    check({tag, ".b_b1"}, 32'(b_b1), 32'(e_b1[1]));
    check({tag, ".b_b2"}, 32'(b_b2), 32'(e_b2[1]));
    check({tag, ".b_bv"}, b_bv, e_bv[1]);
    check({tag, ".c_rd1"}, 32'(c_rd1), e_rd1[2]);
    check({tag, ".c_rd2"}, 32'(c_rd2), e_rd2[2]);
    check({tag, ".c_b1"}, 32'(c_b1), 32'(e_b1[2]));
    check({tag, ".c_b2"}, 32'(c_b2), 32'(e_b2[2]));
    check({tag, ".c_bv"}, 32'(c_bv), e_bv[2]);
  endtask

  task automatic drive(bit rw, bit [4:0] w, bit [31:0] d, bit mk, bit [4:0] ma,
                       bit [4:0] r1, bit [4:0] r2);
    regwr = rw; wr = w; wd = d; mark = mk; mark_addr = ma; rr1 = r1; rr2 = r2;
  endtask

  // advance one edge, update the model, sample 1 time unit later
  task automatic cycle(string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit        regwr;
    bit [4:0]  wr;
    bit [31:0] wd;
    bit        mark;
    bit [4:0]  ma;
    bit [4:0]  rr1;
    bit [4:0]  rr2;
    bit [31:0] a_rd1;
    bit        a_b1;
    bit [31:0] b_rd1;
    bit        b_b1;
  } vec_t;

  vec_t tbl [10];

  initial begin
    //            rw wr wd            mk ma rr1 rr2  a_rd1        a_b b_rd1        b_b
    tbl[0] = '{1, 3, 32'hDEADBEEF, 0, 0, 3, 0, 32'hDEADBEEF, 0, 32'h0,        0};
    tbl[1] = '{0, 0, 32'h0,        0, 0, 3, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    tbl[2] = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0};
    tbl[3] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'hFFFFFFFF, 1};
    tbl[4] = '{0, 0, 32'h0,        1, 5, 5, 5, 32'h0,        1, 32'h0,        0};
    tbl[5] = '{0, 0, 32'h0,        0, 0, 5, 5, 32'h0,        1, 32'h0,        1};
    tbl[6] = '{1, 5, 32'h55,       0, 0, 5, 5, 32'h55,       0, 32'h0,        1};
    tbl[7] = '{0, 0, 32'h0,        0, 0, 5, 5, 32'h55,       0, 32'h55,       0};
    tbl[8] = '{1, 7, 32'h77,       1, 7, 7, 7, 32'h77,       1, 32'h0,        0};
    tbl[9] = '{0, 0, 32'h0,        0, 0, 7, 7, 32'h77,       1, 32'h77,       1};

    // power-on reset: every output defined and zero
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    check("reset.a_bv_zero", a_bv, 32'h0);

    // mid-cycle reset clears data and scoreboard without a clock edge
    @(negedge clk) rst = 1'b0;
    drive(1, 2, 32'h0123, 1, 9, 2, 2);
    cycle("pre_rst_wr");
    check("pre_rst.a_rd1", a_rd1, 32'h0123);
    @(negedge clk) drive(0, 0, 0, 0, 0, 2, 2);
    cycle("pre_rst_rd");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.a_bv", a_bv, 32'h0);
    @(negedge clk) rst = 1'b0;
    cycle("post_rst_rd");
    check("post_rst.b_rd1", b_rd1, 32'h0);

    // directed table: bypass, zero register, scoreboard, collision
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].regwr, tbl[i].wr, tbl[i].wd, tbl[i].mark, tbl[i].ma, tbl[i].rr1, tbl[i].rr2);
      cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.a_rd1", i), a_rd1, tbl[i].a_rd1);
      check($sformatf("tbl%0d.a_b1", i), 32'(a_b1), 32'(tbl[i].a_b1));
      check($sformatf("tbl%0d.b_rd1", i), b_rd1, tbl[i].b_rd1);
      check($sformatf("tbl%0d.b_b1", i), 32'(b_b1), 32'(tbl[i].b_b1));
    end
    check("collision.a_bv7", 32'(a_bv[7]), 32'd1);

    // narrow-file sweep: fill r1..r7 then read every address pair
    for (int i = 1; i < 8; i++) begin
      @(negedge clk) drive(1, 5'(i), 32'(i) * 32'h1111, 0, 0, 0, 0);
      cycle($sformatf("sweep_wr%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        @(negedge clk) drive(0, 0, 0, 0, 0, 5'(i), 5'(j));
        cycle($sformatf("sweep_rd%0d_%0d", i, j));
      end
      check($sformatf("sweep.c_rd1_%0d", i), 32'(c_rd1), 32'(i) * 32'h1111);
    end

    // randomised traffic, biased toward read/write address collisions
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(bit'($urandom_range(0, 1)), 5'($urandom), $urandom, bit'($urandom_range(0, 2) == 0),
            5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) rr1 = wr;
      if ($urandom_range(0, 3) == 0) rr2 = mark_addr;
      if ($urandom_range(0, 7) == 0) mark_addr = wr;
      cycle($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
